// File: rtl/mem_pkg.sv
// Shared memory-channel definitions: the channel_update command flit layout
// and the stream_requester control states.
package mem_pkg;

    typedef struct packed {
        logic [26:0] addr;
        logic [26:0] stream_length;
        logic        wen;
    } channel_update;

    localparam logic CMD_FLIT_TUSER = 1'b1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND_CMD   = 2'd1,
        WRITE_DATA = 2'd2,
        READ_WAIT  = 2'd3
    } req_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered almost-full flag.
module sync_fifo #(
    parameter int WIDTH     = 130,
    parameter int DEPTH     = 32,
    parameter int AF_THRESH = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             af_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             af_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Masked so the read port shows zero rather than stale storage when empty.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign af_o    = af_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            af_q     <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            af_q    <= (count_q >= (AW+1)'(AF_THRESH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/stream_requester.sv
// Client endpoint for one traffic_merger channel: issues the command flit,
// streams write beats, and buffers read responses for the local consumer.
module stream_requester
    import mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 32,
    parameter int AF_MARGIN  = 12
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [26:0]  req_addr,
    input  logic [26:0]  req_length,
    input  logic         req_wen,
    output logic         done,
    input  logic [127:0] src_data,
    input  logic         src_valid,
    output logic         src_ready,
    output logic [127:0] sink_data,
    output logic         sink_first,
    output logic         sink_last,
    output logic         sink_valid,
    input  logic         sink_ready,
    output logic         overflow,
    output logic [127:0] write_axis_data,
    output logic         write_axis_tuser,
    output logic         write_axis_valid,
    output logic         write_axis_smallpile,
    input  logic         write_axis_ready,
    input  logic [127:0] read_axis_data,
    input  logic         read_axis_tuser,
    input  logic         read_axis_valid,
    output logic         read_axis_af,
    output logic         read_axis_ready,
    output logic [1:0]   dbg_state_o
);

    // Handshakes on every port are valid/ready: a transfer happens on the
    // rising edge where both are high; a source holds data steady until then.
    // read_axis is the exception: the merger pushes regardless of ready.

    req_state_e    state_q;
    logic [26:0]   addr_q;
    logic [26:0]   len_q;
    logic          wen_q;
    logic [26:0]   cnt_q;
    logic          done_zero_q;
    logic          overflow_q;

    channel_update cmd;
    logic          last_cnt;
    logic          wr_hs;
    logic          rd_in;
    logic          ovf_event;
    logic          fifo_empty;
    logic          fifo_full;
    logic [129:0]  fifo_dout;

    assign cmd       = '{addr: addr_q, stream_length: len_q, wen: wen_q};
    assign last_cnt  = (cnt_q == len_q - 27'd1);
    assign wr_hs     = (state_q == WRITE_DATA) && src_valid && write_axis_ready;
    assign rd_in     = read_axis_valid && (state_q == READ_WAIT);
    assign ovf_event = read_axis_valid && ((state_q != READ_WAIT) || fifo_full);

    assign req_ready            = (state_q == IDLE);
    assign done                 = done_zero_q || (wr_hs && last_cnt) || (rd_in && last_cnt);
    assign overflow             = overflow_q;
    assign write_axis_smallpile = 1'b0;
    assign read_axis_ready      = 1'b1;
    assign dbg_state_o          = state_q;

    always_comb begin
        write_axis_data  = '0;
        write_axis_tuser = 1'b0;
        write_axis_valid = 1'b0;
        src_ready        = 1'b0;
        case (state_q)
            SEND_CMD: begin
                write_axis_data  = 128'(cmd);
                write_axis_tuser = CMD_FLIT_TUSER;
                write_axis_valid = 1'b1;
            end
            WRITE_DATA: begin
                write_axis_data  = src_data;
                write_axis_valid = src_valid;
                src_ready        = write_axis_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            wen_q       <= 1'b0;
            cnt_q       <= '0;
            done_zero_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_zero_q <= 1'b0;
            if (ovf_event) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        len_q  <= req_length;
                        wen_q  <= req_wen;
                        cnt_q  <= '0;
                        if (req_length == 27'd0) begin
                            done_zero_q <= 1'b1;
                        end else begin
                            state_q <= SEND_CMD;
                        end
                    end
                end
                SEND_CMD: begin
                    if (write_axis_ready) begin
                        state_q <= wen_q ? WRITE_DATA : READ_WAIT;
                    end
                end
                WRITE_DATA: begin
                    if (wr_hs) begin
                        if (last_cnt) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 27'd1;
                        end
                    end
                end
                READ_WAIT: begin
                    // Beats dropped on a full FIFO still count toward the burst.
                    if (read_axis_valid) begin
                        if (last_cnt) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 27'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH     (130),
        .DEPTH     (FIFO_DEPTH),
        .AF_THRESH (FIFO_DEPTH - AF_MARGIN)
    ) u_rsp_fifo (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .push_i  (rd_in),
        .data_i  ({read_axis_tuser, last_cnt, read_axis_data}),
        .pop_i   (sink_ready),
        .data_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .af_o    (read_axis_af)
    );

    assign sink_valid = !fifo_empty;
    assign sink_first = fifo_dout[129];
    assign sink_last  = fifo_dout[128];
    assign sink_data  = fifo_dout[127:0];

endmodule
